// File: rtl/png_pkg.sv
// Shared constants for PNG chunk CRC: CRC-32 parameters, FSM encoding and
// well-known chunk type codes, plus the single-byte reflected CRC step.
package png_pkg;

    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOR  = 32'hFFFF_FFFF;

    localparam logic [31:0] TYP_IHDR = 32'h4948_4452;
    localparam logic [31:0] TYP_IDAT = 32'h4944_4154;
    localparam logic [31:0] TYP_IEND = 32'h4945_4E44;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYP  = 2'd1,
        ST_DAT  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Reflected CRC: byte enters at the LSB end, one shift per bit.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_upd.sv
// Combinational CRC-32 update over the first cnt_i bytes of an MSB-first word.
module crc32_upd
    import png_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [31:0]          crc_i,
    input  logic [NB*8-1:0]      dat_i,
    input  logic [$clog2(NB):0]  cnt_i,
    output logic [31:0]          crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(cnt_i)) begin
                crc_o = crc_byte(crc_o, dat_i[8*(NB-1-i) +: 8]);
            end
        end
    end

endmodule

// File: rtl/png_chunk_crc.sv
// PNG chunk CRC engine: folds the 4-byte type then a byte stream of DATA_WD-wide
// beats into CRC-32, and counts data bytes for the chunk length field.
module png_chunk_crc
    import png_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [31:0]         typ_i,
    input  logic                emp_i,
    input  logic                val_i,
    output logic                rdy_o,
    input  logic [DATA_WD-1:0]  dat_i,
    input  logic                lst_i,
    input  logic [$clog2(DATA_WD/8):0] nbyt_i,
    output logic                busy_o,
    output logic                val_o,
    output logic [31:0]         dat_o,
    output logic [31:0]         len_o,
    output logic                done_o
);

    localparam int NB    = DATA_WD / 8;
    localparam int NB_WD = $clog2(NB) + 1;

    state_t             state;
    logic [31:0]        crc;
    logic [31:0]        typ_q;
    logic               emp_q;
    logic [31:0]        crc_typ;
    logic [31:0]        crc_dat;
    logic [NB_WD-1:0]   cnt;
    logic               beat;

    // Last beat contributes nbyt_i bytes, clamped to the lane count.
    always_comb begin
        cnt = NB_WD'(NB);
        if (lst_i) begin
            cnt = (nbyt_i > NB_WD'(NB)) ? NB_WD'(NB) : nbyt_i;
        end
    end

    assign beat   = (state == ST_DAT) && val_i && rdy_o;
    assign busy_o = (state != ST_IDLE);

    crc32_upd #(.NB(4)) u_crc_typ (
        .crc_i (crc),
        .dat_i (typ_q),
        .cnt_i (3'd4),
        .crc_o (crc_typ)
    );

    crc32_upd #(.NB(NB)) u_crc_dat (
        .crc_i (crc),
        .dat_i (dat_i),
        .cnt_i (cnt),
        .crc_o (crc_dat)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            crc    <= CRC_INIT;
            emp_q  <= 1'b0;
            len_o  <= 32'h0;
            rdy_o  <= 1'b0;
            val_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            val_o  <= 1'b0;
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_TYP;
                        emp_q <= emp_i;
                        crc   <= CRC_INIT;
                        len_o <= 32'h0;
                    end
                end
                ST_TYP: begin
                    crc <= crc_typ;
                    if (emp_q) begin
                        state  <= ST_FIN;
                        val_o  <= 1'b1;
                        done_o <= 1'b1;
                    end else begin
                        state <= ST_DAT;
                        rdy_o <= 1'b1;
                    end
                end
                ST_DAT: begin
                    if (beat) begin
                        crc   <= crc_dat;
                        len_o <= len_o + 32'(cnt);
                        if (lst_i) begin
                            state  <= ST_FIN;
                            rdy_o  <= 1'b0;
                            val_o  <= 1'b1;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    rdy_o <= 1'b0;
                end
            endcase
        end
    end

    // Result and captured type are plain data: loaded on their events, held otherwise.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start_i) begin
            typ_q <= typ_i;
        end
        if (state == ST_TYP && emp_q) begin
            dat_o <= crc_typ ^ CRC_XOR;
        end else if (beat && lst_i) begin
            dat_o <= crc_dat ^ CRC_XOR;
        end
    end

endmodule

// File: tb/tb_png_chunk_crc.sv
// Bench for png_chunk_crc at DATA_WD 8, 32 and 64 against a byte-stream CRC-32 model.
module tb_png_chunk_crc;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rstn;
    logic        start [3];
    logic        emp   [3];
    logic        val   [3];
    logic        lst   [3];
    logic [31:0] typ   [3];
    logic [63:0] dat   [3];
    logic [3:0]  nbyt  [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        valo  [3];
    logic        doneo [3];
    logic [31:0] dato  [3];
    logic [31:0] leno  [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            localparam int W   = (g == 0) ? 8 : (g == 1) ? 32 : 64;
            localparam int NBW = $clog2(W/8) + 1;
            png_chunk_crc #(.DATA_WD(W)) u_dut (
                .clk     (clk),
                .rstn    (rstn),
                .start_i (start[g]),
                .typ_i   (typ[g]),
                .emp_i   (emp[g]),
                .val_i   (val[g]),
                .rdy_o   (rdy[g]),
                .dat_i   (dat[g][63 -: W]),
                .lst_i   (lst[g]),
                .nbyt_i  (nbyt[g][NBW-1:0]),
                .busy_o  (busy[g]),
                .val_o   (valo[g]),
                .dat_o   (dato[g]),
                .len_o   (leno[g]),
                .done_o  (doneo[g])
            );
        end
    endgenerate

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nb_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    function automatic int nbmax_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 7 : 15;
    endfunction

    // Textbook PNG CRC-32 over type bytes followed by data bytes.
    function automatic logic [31:0] crc_ref(input logic [31:0] t, input bq_t d);
        bq_t all;
        logic [31:0] c;
        all = {t[31:24], t[23:16], t[15:8], t[7:0]};
        foreach (d[i]) all.push_back(d[i]);
        c = 32'hFFFF_FFFF;
        foreach (all[i]) begin
            c = c ^ {24'h0, all[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the cycle following FIN.
    task automatic run_chunk(input int k, input string tag, input logic [31:0] t, input logic e,
                             input bq_t b, input int gap_pct, input bit term, input bit over,
                             input logic [31:0] exp_crc);
        int  nb, pos, budget, rem, n;
        bit  done_seen, was_rdy;
        nb = nb_of(k);
        pos = 0;
        start[k] = 1'b1; typ[k] = t; emp[k] = e;
        @(posedge clk); #1;
        start[k] = 1'b0; typ[k] = $urandom; emp[k] = 1'b0;
        if (!e) begin
            budget = 0; done_seen = 1'b0;
            while (!done_seen && budget < 2000) begin
                n = 0;
                dat[k] = {$urandom, $urandom};
                if (int'($urandom_range(99)) < gap_pct) begin
                    val[k] = 1'b0; lst[k] = $urandom; nbyt[k] = $urandom;
                end else begin
                    rem = b.size() - pos;
                    for (int i = 0; i < nb; i++) if (i < rem) dat[k][63-8*i -: 8] = b[pos+i];
                    if (rem > nb || (rem == nb && term)) begin
                        lst[k] = 1'b0; n = nb; nbyt[k] = $urandom;
                    end else if (rem == nb && over && k != 0) begin
                        lst[k] = 1'b1; n = nb;
                        nbyt[k] = 4'($urandom_range(nbmax_of(k), nb + 1));
                    end else begin
                        lst[k] = 1'b1; n = rem; nbyt[k] = 4'(rem);
                    end
                    val[k] = 1'b1;
                end
                was_rdy = rdy[k];
                @(posedge clk); #1;
                if (val[k] && was_rdy) begin
                    pos += n;
                    if (lst[k]) done_seen = 1'b1;
                end
                budget++;
            end
            val[k] = 1'b0; lst[k] = 1'b0;
            chk_eq({tag, "_finished"}, done_seen, 1);
        end else begin
            @(posedge clk); #1;
        end
        chk_eq({tag, "_val"}, valo[k], 1);
        chk_eq({tag, "_done"}, doneo[k], 1);
        chk_eq({tag, "_crc"}, dato[k], exp_crc);
        chk_eq({tag, "_len"}, leno[k], b.size());
        @(posedge clk); #1;
        chk_eq({tag, "_val_drop"}, valo[k], 0);
        chk_eq({tag, "_idle"}, busy[k], 0);
        chk_eq({tag, "_crc_hold"}, dato[k], exp_crc);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t ihdr, none, rnd;
        int  dcnt, len;
        for (int k = 0; k < 3; k++) begin
            start[k] = 0; emp[k] = 0; val[k] = 0; lst[k] = 0;
            typ[k] = 0; dat[k] = 0; nbyt[k] = 0;
        end
        ihdr = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'h08, 8'h06, 8'h00, 8'h00, 8'h00};

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("rst_busy%0d", k), busy[k], 0);
            chk_eq($sformatf("rst_rdy%0d", k), rdy[k], 0);
            chk_eq($sformatf("rst_val%0d", k), valo[k], 0);
            chk_eq($sformatf("rst_done%0d", k), doneo[k], 0);
            chk_eq($sformatf("rst_len%0d", k), leno[k], 0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            run_chunk(k, $sformatf("iend%0d", k), 32'h4945_4E44, 1'b1, none, 0, 0, 0, 32'hAE42_6082);
            run_chunk(k, $sformatf("ihdr%0d", k), 32'h4948_4452, 1'b0, ihdr, 0, 0, 0, 32'h1F15_C489);
        end

        // Random lengths, gaps, empty terminators and over-range nbyt on the last beat.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] t;
                rnd.delete();
                len = (it % 2 == 0) ? nb_of(k) * int'($urandom_range(5, 1)) : int'($urandom_range(40, 1));
                for (int i = 0; i < len; i++) rnd.push_back(8'($urandom));
                t = $urandom;
                run_chunk(k, $sformatf("rnd%0d_%0d", it, k), t, 1'b0, rnd, 35,
                          (it % 4 == 0), (it % 4 == 2), crc_ref(t, rnd));
            end
        end

        // Reset in the middle of a data phase abandons the chunk.
        start[1] = 1'b1; typ[1] = 32'h4944_4154; emp[1] = 1'b0;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (3) begin
            val[1] = 1'b1; lst[1] = 1'b0; dat[1] = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; val[1] = 1'b0;
        chk_eq("midrst_busy", busy[1], 0);
        chk_eq("midrst_rdy", rdy[1], 0);
        chk_eq("midrst_len", leno[1], 0);
        dcnt = 0;
        repeat (4) begin
            if (doneo[1]) dcnt++;
            @(posedge clk); #1;
        end
        chk_eq("midrst_no_done", dcnt, 0);
        run_chunk(1, "midrst_iend", 32'h4945_4E44, 1'b1, none, 0, 0, 0, 32'hAE42_6082);

        // start_i held through FIN must not start a second chunk.
        start[1] = 1'b1; typ[1] = 32'h4945_4E44; emp[1] = 1'b1;
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (doneo[1]) dcnt++;
        end
        start[1] = 1'b0; emp[1] = 1'b0;
        chk_eq("hold_idle_after_fin", busy[1], 0);
        repeat (5) begin
            @(posedge clk); #1;
            if (doneo[1]) dcnt++;
        end
        chk_eq("hold_done_count", dcnt, 1);
        chk_eq("hold_crc", dato[1], 32'hAE42_6082);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/png_chunk_crc.md
PNG_CHUNK_CRC -- requirements
Module: png_chunk_crc

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data-path width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL derive localparam NB = DATA_WD/8 (byte lanes) and NB_WD = $clog2(NB)+1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_i  input  1  begin a chunk; sampled only in IDLE.
REQ-006 SHALL have port typ_i  input  32  chunk type (e.g. 0x49444154 "IDAT"); sampled with start_i.
REQ-007 SHALL have port emp_i  input  1  zero-length chunk (type only); sampled with start_i.
REQ-008 SHALL have port val_i  input  1  data beat valid.
REQ-009 SHALL have port rdy_o  output  1  data beat accepted when val_i && rdy_o.
REQ-010 SHALL have port dat_i  input  DATA_WD  chunk data; MSB byte is first in stream order.
REQ-011 SHALL have port lst_i  input  1  marks last data beat.
REQ-012 SHALL have port nbyt_i  input  NB_WD  valid bytes on last beat, MSB-aligned; ignored when lst_i=0.
REQ-013 SHALL have port busy_o  output  1  high in any state except IDLE.
REQ-014 SHALL have port val_o  output  1  CRC result valid.
REQ-015 SHALL have port dat_o  output  32  CRC-32 of type + data.
REQ-016 SHALL have port len_o  output  32  data byte count (PNG length field), valid with val_o.
REQ-017 SHALL have port done_o  output  1  chunk finished pulse.

Function
REQ-018 SHALL compute PNG CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, bytes LSB-first within each byte.
REQ-019 SHALL implement FSM IDLE -> TYP -> DAT -> FIN -> IDLE; IDLE->TYP on start_i; TYP->FIN if emp captured, else TYP->DAT; DAT->FIN on accepted beat with lst_i=1; FIN->IDLE unconditionally.
REQ-020 SHALL process all 4 typ bytes in the single TYP cycle regardless of DATA_WD.
REQ-021 SHALL drive rdy_o=1 only in DAT; one beat per cycle, no bubbles required.
REQ-022 SHALL fold a non-last beat as NB bytes and a last beat as nbyt_i bytes; nbyt_i=0 contributes no bytes (empty terminator beat legal); nbyt_i>NB clamps to NB.
REQ-023 SHALL accumulate len_o by bytes folded, modulo 2^32, cleared on start.
REQ-024 SHALL assert val_o and done_o for exactly the FIN cycle, dat_o=~crc register; latency = 1 cycle after last-beat handshake (2 cycles after start for empty chunk).
REQ-025 SHALL hold dat_o/len_o stable from FIN until next start_i accepted; val_o=0 outside FIN.
REQ-026 SHALL ignore start_i outside IDLE; start_i during FIN is not queued.
REQ-027 SHALL ignore val_i outside DAT; data bytes beyond nbyt_i ignored.

Reset
REQ-028 SHALL, when rstn=0 at a clock edge, enter IDLE, clear crc to 0xFFFFFFFF, len_o=0, rdy_o=0, val_o=0, done_o=0, busy_o=0.
REQ-029 SHALL abandon an in-progress chunk on reset with no done_o pulse.

Structure
REQ-030 SHALL place CRC polynomial, init/final-XOR constants, FSM state encodings and PNG chunk type constants (IHDR, IDAT, IEND) in shared package png_pkg.
REQ-031 SHALL use one combinational sub-module crc32_upd (parameter NB) folding up to NB bytes with byte count into a 32-bit CRC; instantiated once for typ (NB=4) and once for data.

Verification
REQ-032 SHALL test IEND: start_i, typ_i=0x49454E44, emp_i=1 -> val_o/done_o 2 cycles later, dat_o=0xAE426082, len_o=0.
REQ-033 SHALL test IHDR 1x1 RGBA, DATA_WD=32: typ 0x49484452, beats 0x00000001, 0x00000001, 0x08060000, 0x00xxxxxx lst_i=1 nbyt_i=1 -> dat_o=0x1F15C489, len_o=13.
REQ-034 SHALL repeat REQ-033 at DATA_WD=8 (13 beats) and 64 (2 beats, nbyt_i=5) -> identical dat_o and len_o.
REQ-035 SHALL test random val_i gaps and a final beat with nbyt_i=0 -> CRC equals gap-free, terminator-free reference.
REQ-036 SHALL test rstn=0 mid-DAT -> next cycle IDLE, rdy_o=0, no done_o; following IEND chunk gives 0xAE426082.
REQ-037 SHALL test start_i held high through FIN -> exactly one new chunk starts, from IDLE only.
